mem_bus_arbiter: RTL and testbench

- Shares one SRAM-style memory bus between the instruction-fetch requester and the data (load/store) requester.
- Sits between the IF stage, the EX/MEM load-store path and the external bus bridge.
- The memory stage downstream consumes the routed read data and does its own byte/half extraction.
- Responses return in order; an internal ID FIFO routes each response to the requester that issued it.

---
 rtl/mem_bus_arbiter_pkg.sv | 22 ++
 rtl/mem_bus_arbiter_id_fifo.sv | 62 ++++++
 rtl/mem_bus_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the instruction/data memory bus arbiter:
// requester IDs, bus size encodings, lock state encoding and the
// default number of outstanding bus transactions.
package mem_bus_arbiter_pkg;

  typedef enum logic {
    ARB_ID_INST = 1'b0,
    ARB_ID_DATA = 1'b1
  } arb_id_e;

  typedef enum logic {
    LOCK_OFF = 1'b0,
    LOCK_ON  = 1'b1
  } lock_state_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  localparam int unsigned OUTSTANDING_DEFAULT = 2;

endpackage

// File: rtl/mem_bus_arbiter_id_fifo.sv
// arb_id_fifo: generic depth-parameterised FIFO of 1-bit requester IDs.
// DEPTH must be a power of two so the read/write pointers wrap naturally.
// Push while full and pop while empty are ignored.
module arb_id_fifo #(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic                     head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             mem [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Qualify push/pop against full/empty
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= 1'b0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one SRAM-style bus between instruction fetch and
// the load/store path. Requests are accepted with zero added latency; the
// in-order responses are routed back through an ID FIFO.
// Optional build macro: MEM_ARB_RR_EN selects round-robin arbitration
// (default build: fixed data-over-inst priority, no last_grant register).
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned OUTSTANDING = OUTSTANDING_DEFAULT,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int unsigned CNT_W = $clog2(OUTSTANDING) + 1;

  lock_state_e      lock_state;
  lock_state_e      lock_next;
  arb_id_e          locked_id;
  arb_id_e          locked_id_next;
  arb_id_e          grant;
  logic             grant_valid;
  logic             bus_hs;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_head;
  arb_id_e          head_id;
  logic [CNT_W-1:0] fifo_count;

`ifdef MEM_ARB_RR_EN
  arb_id_e          last_grant;
`endif

  assign head_id = arb_id_e'(fifo_head);
  assign bus_hs  = bus_req & bus_addr_ok;

  // Grant selection: a held lock wins over any policy; a full FIFO
  // blocks everything, even when a pop happens in the same cycle.
  always_comb begin
    grant       = ARB_ID_INST;
    grant_valid = 1'b0;
    if (!fifo_full) begin
      if (lock_state == LOCK_ON) begin
        grant       = locked_id;
        grant_valid = (locked_id == ARB_ID_DATA) ? data_req : inst_req;
      end else begin
`ifdef MEM_ARB_RR_EN
        if (inst_req && data_req) begin
          grant       = (last_grant == ARB_ID_INST) ? ARB_ID_DATA : ARB_ID_INST;
          grant_valid = 1'b1;
        end else if (data_req) begin
          grant       = ARB_ID_DATA;
          grant_valid = 1'b1;
        end else if (inst_req) begin
          grant       = ARB_ID_INST;
          grant_valid = 1'b1;
        end
`else
        if (data_req) begin
          grant       = ARB_ID_DATA;
          grant_valid = 1'b1;
        end else if (inst_req) begin
          grant       = ARB_ID_INST;
          grant_valid = 1'b1;
        end
`endif
      end
    end
  end

  // Drive the shared bus from the granted requester; fetches are word reads
  always_comb begin
    bus_req = grant_valid & ~rst;
    if (grant == ARB_ID_DATA) begin
      bus_wr    = data_wr;
      bus_size  = data_size;
      bus_addr  = data_addr;
      bus_wstrb = data_wstrb;
      bus_wdata = data_wdata;
    end else begin
      bus_wr    = 1'b0;
      bus_size  = SIZE_W;
      bus_addr  = inst_addr;
      bus_wstrb = '0;
      bus_wdata = '0;
    end
  end

  // Request acceptance and in-order response routing
  always_comb begin
    inst_addr_ok = bus_hs & (grant == ARB_ID_INST);
    data_addr_ok = bus_hs & (grant == ARB_ID_DATA);
    inst_data_ok = ~rst & bus_data_ok & ~fifo_empty & (head_id == ARB_ID_INST);
    data_data_ok = ~rst & bus_data_ok & ~fifo_empty & (head_id == ARB_ID_DATA);
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  // Lock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LOCK_OFF;
      locked_id  <= ARB_ID_INST;
    end else begin
      lock_state <= lock_next;
      locked_id  <= locked_id_next;
    end
  end

  // Lock next-state: hold a stalled grant until its address handshake
  always_comb begin
    lock_next      = lock_state;
    locked_id_next = locked_id;
    case (lock_state)
      LOCK_OFF: begin
        if (bus_req && !bus_addr_ok) begin
          lock_next      = LOCK_ON;
          locked_id_next = grant;
        end
      end
      LOCK_ON: begin
        if (bus_hs) begin
          lock_next = LOCK_OFF;
        end
      end
      default: lock_next = LOCK_OFF;
    endcase
  end

`ifdef MEM_ARB_RR_EN
  // Round-robin history: remember who won the last bus handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ARB_ID_INST;
    end else if (bus_hs) begin
      last_grant <= grant;
    end
  end
`endif

  // Responses come back in order; the FIFO remembers who issued each request
  arb_id_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_id_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus_hs),
    .din   (grant),
    .pop   (bus_data_ok),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head),
    .count (fifo_count)
  );

`ifndef SYNTHESIS
  // A response with nothing outstanding is a bus protocol violation; it is dropped
  assert property (@(posedge clk) disable iff (rst) !(bus_data_ok && fifo_empty))
    else $warning("mem_bus_arbiter: bus_data_ok with no outstanding request, response dropped");
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: stimulus pushes expected bus
// transactions and responses; a negedge monitor pops and compares them.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok;
  logic          inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [SW-1:0] data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req;
  logic          bus_wr;
  logic [1:0]    bus_size;
  logic [AW-1:0] bus_addr;
  logic [SW-1:0] bus_wstrb;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok;
  logic          bus_data_ok;
  logic [DW-1:0] bus_rdata;

  mem_bus_arbiter #(
    .OUTSTANDING (2),
    .ADDR_W      (AW),
    .DATA_W      (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .bus_req      (bus_req),
    .bus_wr       (bus_wr),
    .bus_size     (bus_size),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_addr_ok  (bus_addr_ok),
    .bus_data_ok  (bus_data_ok),
    .bus_rdata    (bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          wr;
    logic [1:0]    size;
    logic [SW-1:0] wstrb;
    logic [DW-1:0] wdata;
  } bus_txn_t;

  bus_txn_t      exp_bus_q[$];
  logic [DW-1:0] exp_inst_q[$];
  logic [DW-1:0] exp_data_q[$];
  int            n_cmp = 0;
  int            n_bad = 0;
  bus_txn_t      mon_got;
  bus_txn_t      mon_exp;
  logic [DW-1:0] mon_word;

  function automatic bus_txn_t mk_txn(input logic [AW-1:0] a, input logic w,
                                      input logic [1:0] s, input logic [SW-1:0] b,
                                      input logic [DW-1:0] d);
    bus_txn_t t;
    t.addr  = a;
    t.wr    = w;
    t.size  = s;
    t.wstrb = b;
    t.wdata = d;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every handshake and every response is checked
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_req && bus_addr_ok) begin
        mon_got = mk_txn(bus_addr, bus_wr, bus_size, bus_wstrb, bus_wdata);
        n_cmp++;
        if (exp_bus_q.size() == 0) begin
          n_bad++;
          $display("FAIL bus_txn: unexpected handshake addr 0x%0h", bus_addr);
        end else begin
          mon_exp = exp_bus_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_bad++;
            $display("FAIL bus_txn: got addr 0x%0h wr %0b size %0d strb 0x%0h wdata 0x%0h expected addr 0x%0h wr %0b size %0d strb 0x%0h wdata 0x%0h",
                     mon_got.addr, mon_got.wr, mon_got.size, mon_got.wstrb, mon_got.wdata,
                     mon_exp.addr, mon_exp.wr, mon_exp.size, mon_exp.wstrb, mon_exp.wdata);
          end
        end
      end
      if (inst_data_ok) begin
        n_cmp++;
        if (exp_inst_q.size() == 0) begin
          n_bad++;
          $display("FAIL inst_resp: unexpected inst_data_ok rdata 0x%0h", inst_rdata);
        end else begin
          mon_word = exp_inst_q.pop_front();
          if (inst_rdata !== mon_word) begin
            n_bad++;
            $display("FAIL inst_resp: got 0x%0h expected 0x%0h", inst_rdata, mon_word);
          end
        end
      end
      if (data_data_ok) begin
        n_cmp++;
        if (exp_data_q.size() == 0) begin
          n_bad++;
          $display("FAIL data_resp: unexpected data_data_ok rdata 0x%0h", data_rdata);
        end else begin
          mon_word = exp_data_q.pop_front();
          if (data_rdata !== mon_word) begin
            n_bad++;
            $display("FAIL data_resp: got 0x%0h expected 0x%0h", data_rdata, mon_word);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_wr     = 1'b0;
    data_size   = SIZE_W;
    data_addr   = '0;
    data_wstrb  = '0;
    data_wdata  = '0;
    bus_addr_ok = 1'b0;
    bus_data_ok = 1'b0;
    bus_rdata   = '0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset: outputs forced low even with everything asserted
    inst_req    = 1'b1;
    data_req    = 1'b1;
    bus_addr_ok = 1'b1;
    bus_data_ok = 1'b1;
    #2;
    check("rst_bus_req", bus_req, 0);
    check("rst_inst_addr_ok", inst_addr_ok, 0);
    check("rst_data_addr_ok", data_addr_ok, 0);
    check("rst_inst_data_ok", inst_data_ok, 0);
    check("rst_data_data_ok", data_data_ok, 0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    #1;
    check("rst_count", dut.fifo_count, 0);

    // Single fetch, response two cycles later
    tick();
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; bus_addr_ok = 1'b1;
    exp_bus_q.push_back(mk_txn(32'h1C00_0000, 1'b0, SIZE_W, '0, '0));
    #1;
    check("t1_inst_addr_ok", inst_addr_ok, 1);
    check("t1_data_addr_ok", data_addr_ok, 0);
    tick();
    idle();
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h0280_0000;
    exp_inst_q.push_back(32'h0280_0000);
    #1;
    check("t1_data_data_ok", data_data_ok, 0);
    tick();
    idle();

    // Contention, then full with a same-cycle pop (bubble)
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0200;
    data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_W; data_addr = 32'h0000_0100;
    data_wstrb = 4'b0011; data_wdata = 32'hDEAD_BEEF; bus_addr_ok = 1'b1;
    exp_bus_q.push_back(mk_txn(32'h0000_0100, 1'b1, SIZE_W, 4'b0011, 32'hDEAD_BEEF));
    #1;
    check("t2_data_first", data_addr_ok, 1);
    check("t2_inst_waits", inst_addr_ok, 0);
    tick();
    data_wr = 1'b0; data_size = SIZE_H; data_addr = 32'h0000_0104;
    data_wstrb = '0; data_wdata = '0;
`ifdef MEM_ARB_RR_EN
    exp_bus_q.push_back(mk_txn(32'h0000_0200, 1'b0, SIZE_W, '0, '0));
    #1;
    check("t2_rr_inst_second", inst_addr_ok, 1);
`else
    exp_bus_q.push_back(mk_txn(32'h0000_0104, 1'b0, SIZE_H, '0, '0));
    #1;
    check("t2_fixed_data_again", data_addr_ok, 1);
`endif
    tick();
`ifdef MEM_ARB_RR_EN
    inst_req = 1'b0;
`else
    data_req = 1'b0;
`endif
    bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_0001;
    exp_data_q.push_back(32'hAAAA_0001);
    #1;
    check("t2_full_bubble", bus_req, 0);
    tick();
    bus_rdata = 32'hAAAA_0002;
`ifdef MEM_ARB_RR_EN
    exp_inst_q.push_back(32'hAAAA_0002);
    exp_bus_q.push_back(mk_txn(32'h0000_0104, 1'b0, SIZE_H, '0, '0));
`else
    exp_data_q.push_back(32'hAAAA_0002);
    exp_bus_q.push_back(mk_txn(32'h0000_0200, 1'b0, SIZE_W, '0, '0));
`endif
    #1;
    check("t2_after_bubble", bus_req, 1);
    tick();
    inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_rdata = 32'hAAAA_0003;
`ifdef MEM_ARB_RR_EN
    exp_data_q.push_back(32'hAAAA_0003);
`else
    exp_inst_q.push_back(32'hAAAA_0003);
`endif
    tick();
    idle();
    #1;
    check("t2_count", dut.fifo_count, 0);

    // Lock: stalled inst request holds the bus against a later data request
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0300;
    #1;
    check("t3_c0_addr", bus_addr, 32'h0000_0300);
    check("t3_c0_inst_ok", inst_addr_ok, 0);
    tick();
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h0000_0400;
    #1;
    check("t3_c1_addr", bus_addr, 32'h0000_0300);
    check("t3_c1_wr", bus_wr, 0);
    check("t3_c1_data_ok", data_addr_ok, 0);
    tick();
    #1;
    check("t3_c2_addr", bus_addr, 32'h0000_0300);
    check("t3_c2_data_ok", data_addr_ok, 0);
    tick();
    bus_addr_ok = 1'b1;
    exp_bus_q.push_back(mk_txn(32'h0000_0300, 1'b0, SIZE_W, '0, '0));
    #1;
    check("t3_inst_hs", inst_addr_ok, 1);
    check("t3_data_held", data_addr_ok, 0);
    tick();
    inst_req = 1'b0;
    exp_bus_q.push_back(mk_txn(32'h0000_0400, 1'b0, SIZE_W, '0, '0));
    #1;
    check("t3_data_hs", data_addr_ok, 1);
    tick();
    data_req = 1'b0; bus_addr_ok = 1'b0;
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_00B0;
    exp_inst_q.push_back(32'h0000_00B0);
    tick();
    bus_rdata = 32'h0000_00B1;
    exp_data_q.push_back(32'h0000_00B1);
    tick();
    idle();

    // Ordering: inst, data, inst with responses 0xA, 0xB, 0xC
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0500; bus_addr_ok = 1'b1;
    exp_bus_q.push_back(mk_txn(32'h0000_0500, 1'b0, SIZE_W, '0, '0));
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h0000_0600;
    exp_bus_q.push_back(mk_txn(32'h0000_0600, 1'b0, SIZE_W, '0, '0));
    tick();
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0504;
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_000A;
    exp_inst_q.push_back(32'h0000_000A);
    #1;
    check("t4_full", bus_req, 0);
    tick();
    bus_rdata = 32'h0000_000B;
    exp_data_q.push_back(32'h0000_000B);
    exp_bus_q.push_back(mk_txn(32'h0000_0504, 1'b0, SIZE_W, '0, '0));
    #1;
    check("t4_third_accept", inst_addr_ok, 1);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b0;
    bus_rdata = 32'h0000_000C;
    exp_inst_q.push_back(32'h0000_000C);
    tick();
    idle();
    #1;
    check("t4_count", dut.fifo_count, 0);

    // Reset with two in flight, then a stray response
    tick();
    inst_req = 1'b1; inst_addr = 32'h0000_0700; bus_addr_ok = 1'b1;
    exp_bus_q.push_back(mk_txn(32'h0000_0700, 1'b0, SIZE_W, '0, '0));
    tick();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h0000_0800;
    exp_bus_q.push_back(mk_txn(32'h0000_0800, 1'b0, SIZE_W, '0, '0));
    tick();
    idle();
    #1;
    check("t5_inflight", dut.fifo_count, 2);
    rst = 1'b1;
    #1;
    check("t5_rst_count", dut.fifo_count, 0);
    tick();
    rst = 1'b0;
    tick();
    bus_data_ok = 1'b1; bus_rdata = 32'h0000_00EE;
    #1;
    check("t5_no_inst_resp", inst_data_ok, 0);
    check("t5_no_data_resp", data_data_ok, 0);
    tick();
    idle();
    #1;
    check("t5_count", dut.fifo_count, 0);

    // Everything expected must have been observed
    tick();
    check("end_bus_q", exp_bus_q.size(), 0);
    check("end_inst_q", exp_inst_q.size(), 0);
    check("end_data_q", exp_data_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
